// File: rtl/phy_pkg.sv
// Shared PHY definitions: the COM idle/alignment symbol and the receive-side
// alignment state encoding, used by both the serializer and the deserializer.
package phy_pkg;

  localparam logic [7:0] COM_BYTE      = 8'hBC;
  localparam int         COM_COUNT_DEF = 4;
  localparam int         CNT_W_DEF     = 3;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCK   = 2'd1,
    ACTIVE = 2'd2
  } rx_state_t;

  function automatic logic is_com(input logic [7:0] b);
    return b == COM_BYTE;
  endfunction

endpackage

// File: rtl/serial_paralelo_if.sv
// Deserializer bus: the serial bit in, the recovered byte stream out, and the
// alignment state for observation.
interface serial_paralelo_if;
  import phy_pkg::*;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       active;
  rx_state_t  state;

  // The byte stream has no back-pressure: byte_stb is a one-cycle strobe that
  // fires when data_out/valid_out take a new byte, and the consumer must take it.
  modport master (
    output data_in,
    input  data_out, valid_out, byte_stb, active, state
  );

  modport slave (
    input  data_in,
    output data_out, valid_out, byte_stb, active, state
  );

endinterface

// File: rtl/serial_paralelo_com_aligner.sv
// Byte alignment: shifts in serial bits, hunts for COM symbols and locks the
// byte boundary after COM_COUNT consecutive aligned COM bytes.
module com_aligner
  import phy_pkg::*;
#(
  parameter int COM_COUNT = COM_COUNT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] win,
  output logic       boundary,
  output logic       active,
  output rx_state_t  state
);

  logic [6:0]       shreg;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] com_cnt;

  assign win      = {shreg, data_in};
  assign boundary = (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      com_cnt <= '0;
      state   <= SEARCH;
      active  <= 1'b0;
    end else begin
      shreg   <= win[6:0];
      bit_cnt <= bit_cnt + 3'd1;
      case (state)
        SEARCH: begin
          // Any bit position may start a byte; a COM here defines the boundary.
          if (is_com(win)) begin
            com_cnt <= CNT_W'(1);
            bit_cnt <= '0;
            if (COM_COUNT == 1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= LOCK;
            end
          end
        end
        LOCK: begin
          if (boundary) begin
            if (is_com(win)) begin
              com_cnt <= com_cnt + CNT_W'(1);
              if (com_cnt + CNT_W'(1) == CNT_W'(COM_COUNT)) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              com_cnt <= '0;
              state   <= SEARCH;
            end
          end
        end
        ACTIVE: begin
          // Sticky until reset; loss of lock is not detected here.
        end
        default: begin
          state  <= SEARCH;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/serial_paralelo.sv
// PHY receive deserializer: aligns on COM symbols and presents each aligned
// byte with a valid flag (COM -> idle) and a one-cycle strobe.
module serial_paralelo
  import phy_pkg::*;
#(
  parameter int COM_COUNT = COM_COUNT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic               clk_32f,
  input  logic               reset,
  serial_paralelo_if.slave   bus
);

  logic [7:0] win;
  logic       boundary;
  logic       active;
  rx_state_t  state;

  logic [7:0] data_q;
  logic       valid_q;
  logic       stb_q;

  com_aligner #(
    .COM_COUNT (COM_COUNT),
    .CNT_W     (CNT_W)
  ) u_aligner (
    .clk      (clk_32f),
    .reset    (reset),
    .data_in  (bus.data_in),
    .win      (win),
    .boundary (boundary),
    .active   (active),
    .state    (state)
  );

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      stb_q   <= 1'b0;
    end else if (active && boundary) begin
      data_q  <= win;
      valid_q <= !is_com(win);
      stb_q   <= 1'b1;
    end else begin
      stb_q   <= 1'b0;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.byte_stb  = stb_q;
  assign bus.active    = active;
  assign bus.state     = state;

endmodule
